mac_accum: RTL
==============

# mac_accum

Two-stage multiply-accumulate stage that sits directly downstream of the 4x4 Wallace-tree `multiplier`. It registers 4-bit operand pairs, drives them into an internal `multiplier` instance, and accumulates the 8-bit products of a group of beats (terminated by `in_last`) into a wide sum. Each completed group is presented as a single result word on a valid/ready output port. This is the first clocked consumer of the combinational multiplier array.

## Interface
- `ACC_W`, 16: accumulator and result width. Legal range is ACC_W ≥ 8.
- `CNT_W`, 4: width of the beat counter for each group.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_a` in 4: multiplicand (unsigned).
- `in_b` in 4: multiplier (unsigned).
- `in_last` in 1: this beat closes the current group.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_sum` out ACC_W: group sum of products, modulo 2^ACC_W.
- `out_count` out CNT_W: number of beats in the group, saturating.
- `out_ovf` out 1: a carry out of ACC_W occurred at least once in this group.

## Operation
- **Stage 1 (operand register).**
  - On an `in_valid && in_ready` edge, capture `in_a`, `in_b` and `in_last` into `s1_a`, `s1_b` and `s1_last`, and set `s1_valid`.
  - `s1_a` and `s1_b` feed the `multiplier` instance. Its 8-bit product `p` is used combinationally by stage 2.
- **Stage 2 (accumulate).** Stage 2 consumes the stage-1 beat (`s2_take`) when `s1_valid && !(s1_last && out_valid && !out_ready)`.
  - **Non-last beat:**
    - `acc <= acc + zext(p)`, with the carry out of bit ACC_W-1 ORed into sticky `ovf`.
    - `cnt <= cnt + 1`, saturating at 2^CNT_W − 1.
  - **Last beat:**
    - `out_sum <= acc + zext(p)`.
    - `out_count <= sat(cnt + 1)`.
    - `out_ovf <= ovf | carry`.
    - `out_valid <= 1`.
    - Same edge: `acc`, `cnt` and `ovf` are cleared to 0.
- **Stage 1 control.**
  - `s1_valid` clears on a `s2_take` edge with no new capture.
  - `in_ready = !s1_valid || s2_take`. This is combinational and gives a bubble-free pipeline.
- **Output register.**
  - `out_valid` clears on an `out_valid && out_ready` edge unless a new last beat loads on the same edge. In that case the new result overwrites and `out_valid` stays 1.
  - `out_sum`, `out_count` and `out_ovf` are held stable while `out_valid && !out_ready`.
- **Arithmetic.**
  - All values are unsigned.
  - The product is zero-extended to ACC_W.
  - Sums wrap modulo 2^ACC_W.
- **Non-last beats while a result is pending.** They keep accumulating the next group while a result waits. Only a second last beat stalls.
- **Reset** (`rst_n` low at an edge):
  - `s1_valid`, `out_valid`, `out_ovf` and `ovf` become 0.
  - `acc`, `cnt`, `out_sum` and `out_count` become 0.
  - `s1_a`, `s1_b` and `s1_last` become 0.
  - A partial group in flight is discarded, and no result is emitted for it.

## Timing
- `in_ready` is 1 during and after reset.
- Latency: a beat accepted at edge E0 is accumulated at E1. If it is last, `out_valid` is high from E1 until it is popped.
- Throughput: one beat per cycle sustained while `out_ready` = 1. Back-to-back single-beat groups each produce one result per cycle.
- **Stall:**
  - Stage 1 holds a last beat while the output is full and not ready. `in_ready` is 0.
  - `in_ready` rises in the same cycle `out_ready` is asserted, because the pop and the load happen on the same edge.
- `in_a`, `in_b` and `in_last` are ignored when `in_valid` is 0. `out_ready` is ignored when `out_valid` is 0.
- There are no combinational paths from `in_*` to `out_*`. The only combinational path is `out_ready` → `in_ready`.

## Test plan
- **Basic group.** Beats (3,5), (15,15), (0,9,last) with `out_ready` = 1. Expect exactly one result: `out_sum` = 240, `out_count` = 3, `out_ovf` = 0, with `out_valid` high 2 cycles after the first `in_valid` of the last beat.
- **Back-to-back single-beat groups.** (15,15,last) then (2,7,last) on consecutive cycles. Expect results 225/count 1 and 14/count 1 on consecutive cycles, with `in_ready` never low.
- **Backpressure.** `out_ready` = 0, two groups: (1,1,last), then (4,4) and (2,2,last).
  - First result 1 is held stable.
  - (4,4) is accepted.
  - `in_ready` drops while (2,2,last) sits in stage 1.
  - After `out_ready` = 1, expect 1 and then 20, with no loss or duplication.
- **Overflow (ACC_W = 8).** (15,15), (15,15,last). Expect `out_sum` = 194, `out_ovf` = 1, `out_count` = 2. The next group (1,1,last) gives `out_ovf` = 0.
- **Reset mid-group.** Beats (5,5), (6,6), then `rst_n` low for 1 cycle, then (2,3,last). Expect all outputs 0 during reset and a single result of 6 with count 1.
- **Count saturation (CNT_W = 4).** 20 beats of (1,1), the last flagged. Expect `out_sum` = 20 and `out_count` = 15.

Source files
------------

// File: rtl/mac_accum.sv
// Multiply-accumulate stage: registers 4x4 operand beats, multiplies them and sums each
// group of beats (closed by in_last) into one result word.
// Latency: a beat accepted at edge E0 is accumulated at E1; a last beat's result is valid from E1.
// Backpressure: non-last beats keep flowing while a result waits; a second last beat stalls in stage 1.
//
// Ports:
//   clk, rst_n                        - clock, synchronous active-low reset
//   in_valid/in_ready                 - operand beat handshake
//   in_a, in_b, in_last               - unsigned 4-bit operands, end-of-group flag
//   out_valid/out_ready               - result handshake
//   out_sum, out_count, out_ovf       - group sum (mod 2^ACC_W), saturating beat count, sticky carry-out

// 4x4 unsigned multiplier built as a carry-save (Wallace-style) tree.
// Latency: combinational.
// Backpressure: none.
module multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [7:0] r0, r1, r2, r3;
  logic [7:0] s1, c1, s2, c2;

  // Shifted partial-product rows.
  assign r0 = {4'b0000, a & {4{b[0]}}};
  assign r1 = {3'b000,  a & {4{b[1]}}, 1'b0};
  assign r2 = {2'b00,   a & {4{b[2]}}, 2'b00};
  assign r3 = {1'b0,    a & {4{b[3]}}, 3'b000};

  // Two levels of 3:2 compression, then one carry-propagate add. A carry shifted out of
  // bit 7 is harmless: the true product never exceeds 225, so the mod-256 sum is exact.
  assign s1 = r0 ^ r1 ^ r2;
  assign c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
  assign s2 = s1 ^ c1 ^ r3;
  assign c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
  assign p  = s2 + c2;

endmodule

module mac_accum #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Stage 1: operand register
  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_a_q, s1_a_d;
  logic [3:0]       s1_b_q, s1_b_d;
  logic             s1_last_q, s1_last_d;

  // Stage 2: running group state
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [7:0]       prod;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [CNT_W-1:0] cnt_inc;
  logic             s2_take;
  logic             in_take;
  logic             out_pop;

  multiplier u_mult (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (prod)
  );

  // One extra bit on the adder exposes the carry out of the accumulator.
  assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(prod);
  assign carry   = sum_ext[ACC_W];
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Only a last beat needs the output register, so only it can stall stage 2.
  assign s2_take  = s1_valid_q && !(s1_last_q && out_valid_q && !out_ready);
  assign in_ready = !s1_valid_q || s2_take;
  assign in_take  = in_valid && in_ready;
  assign out_pop  = out_valid_q && out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_last_d   = s1_last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (in_take) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_last_d  = in_last;
    end else if (s2_take) begin
      s1_valid_d = 1'b0;
    end

    if (out_pop) begin
      out_valid_d = 1'b0;
    end

    if (s2_take) begin
      if (s1_last_q) begin
        // Close the group; a load on the same edge as a pop overrides the clear.
        out_valid_d = 1'b1;
        out_sum_d   = sum_ext[ACC_W-1:0];
        out_count_d = cnt_inc;
        out_ovf_d   = ovf_q | carry;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_ext[ACC_W-1:0];
        cnt_d = cnt_inc;
        ovf_d = ovf_q | carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
